// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator: programmable scan timing with frame-boundary
// reconfiguration, pixel request lead, panel power-up sequence and PWM backlight.
module lcd_timing_gen #(
    parameter int unsigned CW       = 12,
    parameter int unsigned DW       = 24,
    parameter int unsigned REQ_LEAD = 1,
    parameter int unsigned RST_HOLD = 1000,
    parameter int unsigned BL_DELAY = 2000,
    parameter int unsigned PWM_W    = 8
) (
    input  logic          lcd_pclk,
    input  logic          rst,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_back,
    input  logic [CW-1:0] cfg_h_disp,
    input  logic [CW-1:0] cfg_h_front,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_back,
    input  logic [CW-1:0] cfg_v_disp,
    input  logic [CW-1:0] cfg_v_front,
    input  logic          cfg_hs_pol,
    input  logic          cfg_vs_pol,
    input  logic          cfg_de_mode,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic          cfg_err,
    input  logic [PWM_W-1:0] bl_duty,
    output logic          pixel_req,
    output logic [CW-1:0] pixel_xpos,
    output logic [CW-1:0] pixel_ypos,
    input  logic [DW-1:0] pixel_data,
    output logic          frame_start,
    output logic          line_start,
    output logic [CW-1:0] h_disp,
    output logic [CW-1:0] v_disp,
    output logic          lcd_de,
    output logic          lcd_hs,
    output logic          lcd_vs,
    output logic          lcd_bl,
    output logic          lcd_rst,
    output logic          lcd_clk,
    output logic [DW-1:0] lcd_rgb
);

    localparam int unsigned PMAX = (RST_HOLD > BL_DELAY) ? RST_HOLD : BL_DELAY;
    localparam int unsigned PCW  = $clog2(PMAX + 1);
    localparam int unsigned TW   = CW + 2;

    // Timing set; front porches are folded into the stored totals.
    typedef struct packed {
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_back;
        logic [CW-1:0] h_disp;
        logic [CW-1:0] h_total;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_back;
        logic [CW-1:0] v_disp;
        logic [CW-1:0] v_total;
        logic          hs_pol;
        logic          vs_pol;
        logic          de_mode;
    } timing_t;

    localparam timing_t CFG_RST = '{
        h_sync: CW'(41), h_back: CW'(2), h_disp: CW'(480), h_total: CW'(525),
        v_sync: CW'(10), v_back: CW'(2), v_disp: CW'(272), v_total: CW'(286),
        hs_pol: 1'b0, vs_pol: 1'b0, de_mode: 1'b1
    };

    typedef enum logic [1:0] {PWR_RST, PWR_WAIT, RUN} pwr_state_t;

    pwr_state_t       state_q, state_d;
    logic [PCW-1:0]   pwr_cnt_q, pwr_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic             lcd_rst_q, lcd_rst_d;
    logic             lcd_bl_q, lcd_bl_d;

    timing_t          act_q, shd_q, cfg_in;
    logic             cfg_ready_q, cfg_err_q;
    logic [TW-1:0]    h_tot_new, v_tot_new;
    logic             cfg_bad, cfg_take, xfer;

    logic [CW-1:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic             scan_en, h_last, v_last;
    logic [CW-1:0]    h_start, h_end, v_start, v_end;
    logic             act_d, hs1_d, vs1_d;
    logic [CW-1:0]    xpos_d, ypos_d;

    logic             pixel_req_q, frame_start_q, line_start_q, hs1_q, vs1_q;
    logic [CW-1:0]    xpos_q, ypos_q;
    logic [REQ_LEAD-1:0] de_sr_q, de_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
    logic [DW-1:0]    lcd_rgb_q;

    // Power sequencer state register.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            state_q   <= PWR_RST;
            pwr_cnt_q <= '0;
            lcd_rst_q <= 1'b0;
            lcd_bl_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            lcd_rst_q <= lcd_rst_d;
            lcd_bl_q  <= lcd_bl_d;
        end
    end

    // Power sequencer next state, panel reset and backlight.
    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q + PCW'(1);
        case (state_q)
            PWR_RST: begin
                if (pwr_cnt_q == PCW'(RST_HOLD - 1)) begin
                    state_d   = PWR_WAIT;
                    pwr_cnt_d = '0;
                end
            end
            PWR_WAIT: begin
                if (pwr_cnt_q == PCW'(BL_DELAY - 1)) begin
                    state_d   = RUN;
                    pwr_cnt_d = '0;
                end
            end
            RUN: begin
                pwr_cnt_d = '0;
            end
            default: begin
                state_d   = PWR_RST;
                pwr_cnt_d = '0;
            end
        endcase
        lcd_rst_d = (state_d != PWR_RST);
        lcd_bl_d  = (state_d == RUN) && ((&bl_duty) || (pwm_cnt_q < bl_duty));
    end

    // Free-running PWM phase counter.
    always_ff @(posedge lcd_pclk) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end

    // Config validation and shadow-to-active transfer condition.
    always_comb begin
        h_tot_new = TW'(cfg_h_sync) + TW'(cfg_h_back) + TW'(cfg_h_disp) + TW'(cfg_h_front);
        v_tot_new = TW'(cfg_v_sync) + TW'(cfg_v_back) + TW'(cfg_v_disp) + TW'(cfg_v_front);
        cfg_bad   = (cfg_h_disp == '0) || (cfg_v_disp == '0) ||
                    (h_tot_new[TW-1:CW] != '0) || (v_tot_new[TW-1:CW] != '0);
        cfg_take  = cfg_valid && cfg_ready_q;
        cfg_in    = '{
            h_sync: cfg_h_sync, h_back: cfg_h_back, h_disp: cfg_h_disp,
            h_total: h_tot_new[CW-1:0],
            v_sync: cfg_v_sync, v_back: cfg_v_back, v_disp: cfg_v_disp,
            v_total: v_tot_new[CW-1:0],
            hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol, de_mode: cfg_de_mode
        };
        scan_en   = (state_q != PWR_RST);
        h_last    = (h_cnt_q == act_q.h_total - CW'(1));
        v_last    = (v_cnt_q == act_q.v_total - CW'(1));
        xfer      = !cfg_ready_q && ((state_q == PWR_RST) || (scan_en && h_last && v_last));
    end

    // Active and shadow timing registers.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            act_q       <= CFG_RST;
            shd_q       <= CFG_RST;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= cfg_take && cfg_bad;
            if (cfg_take && !cfg_bad) begin
                shd_q       <= cfg_in;
                cfg_ready_q <= 1'b0;
            end else if (xfer) begin
                act_q       <= shd_q;
                cfg_ready_q <= 1'b1;
            end
        end
    end

    // Scan counters and request-side decode.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!scan_en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
        end else begin
            h_cnt_d = h_cnt_q + CW'(1);
        end

        h_start = act_q.h_sync + act_q.h_back;
        h_end   = h_start + act_q.h_disp;
        v_start = act_q.v_sync + act_q.v_back;
        v_end   = v_start + act_q.v_disp;
        act_d   = scan_en && (h_cnt_q >= h_start) && (h_cnt_q < h_end) &&
                  (v_cnt_q >= v_start) && (v_cnt_q < v_end);
        xpos_d  = act_d ? h_cnt_q - h_start : '0;
        ypos_d  = act_d ? v_cnt_q - v_start : '0;

        hs1_d = 1'b1;
        vs1_d = 1'b1;
        if (scan_en && !act_q.de_mode) begin
            hs1_d = (h_cnt_q < act_q.h_sync) ? act_q.hs_pol : ~act_q.hs_pol;
            vs1_d = (v_cnt_q < act_q.v_sync) ? act_q.vs_pol : ~act_q.vs_pol;
        end
    end

    // Scan counter registers.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Request-side output stage, one cycle behind the counters.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            pixel_req_q   <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
        end else begin
            pixel_req_q   <= act_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            frame_start_q <= act_d && (xpos_d == '0) && (ypos_d == '0);
            line_start_q  <= act_d && (xpos_d == '0);
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
        end
    end

    // Panel-side delay line covering the upstream fetch latency.
    always_comb begin
        de_sr_d    = de_sr_q;
        hs_sr_d    = hs_sr_q;
        vs_sr_d    = vs_sr_q;
        de_sr_d[0] = pixel_req_q;
        hs_sr_d[0] = hs1_q;
        vs_sr_d[0] = vs1_q;
        for (int unsigned i = 1; i < REQ_LEAD; i++) begin
            de_sr_d[i] = de_sr_q[i-1];
            hs_sr_d[i] = hs_sr_q[i-1];
            vs_sr_d[i] = vs_sr_q[i-1];
        end
    end

    // Panel-side registers; pixel captured on every edge that leaves DE high.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            de_sr_q   <= '0;
            hs_sr_q   <= '1;
            vs_sr_q   <= '1;
            lcd_rgb_q <= '0;
        end else begin
            de_sr_q   <= de_sr_d;
            hs_sr_q   <= hs_sr_d;
            vs_sr_q   <= vs_sr_d;
            lcd_rgb_q <= de_sr_d[REQ_LEAD-1] ? pixel_data : '0;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign pixel_req   = pixel_req_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign h_disp      = act_q.h_disp;
    assign v_disp      = act_q.v_disp;
    assign lcd_de      = de_sr_q[REQ_LEAD-1];
    assign lcd_hs      = hs_sr_q[REQ_LEAD-1];
    assign lcd_vs      = vs_sr_q[REQ_LEAD-1];
    assign lcd_bl      = lcd_bl_q;
    assign lcd_rst     = lcd_rst_q;
    assign lcd_clk     = lcd_pclk;
    assign lcd_rgb     = lcd_rgb_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: power-up, scan geometry, data path,
// sync mode, reconfiguration, rejected configs, PWM and mid-frame reset.
module tb_lcd_timing_gen;

    localparam int unsigned CW       = 12;
    localparam int unsigned DW       = 24;
    localparam int unsigned REQ_LEAD = 2;
    localparam int unsigned RST_HOLD = 4;
    localparam int unsigned BL_DELAY = 8;
    localparam int unsigned PWM_W    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [CW-1:0] cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front;
    logic [CW-1:0] cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front;
    logic          cfg_hs_pol, cfg_vs_pol, cfg_de_mode, cfg_valid;
    logic          cfg_ready, cfg_err;
    logic [PWM_W-1:0] bl_duty;
    logic          pixel_req, frame_start, line_start;
    logic [CW-1:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
    logic [DW-1:0] pixel_data, lcd_rgb;
    logic          lcd_de, lcd_hs, lcd_vs, lcd_bl, lcd_rst, lcd_clk;

    int checks = 0;
    int errors = 0;

    lcd_timing_gen #(
        .CW(CW), .DW(DW), .REQ_LEAD(REQ_LEAD),
        .RST_HOLD(RST_HOLD), .BL_DELAY(BL_DELAY), .PWM_W(PWM_W)
    ) dut (
        .lcd_pclk(clk), .rst(rst),
        .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
        .cfg_h_disp(cfg_h_disp), .cfg_h_front(cfg_h_front),
        .cfg_v_sync(cfg_v_sync), .cfg_v_back(cfg_v_back),
        .cfg_v_disp(cfg_v_disp), .cfg_v_front(cfg_v_front),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .cfg_de_mode(cfg_de_mode), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .bl_duty(bl_duty),
        .pixel_req(pixel_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .pixel_data(pixel_data), .frame_start(frame_start), .line_start(line_start),
        .h_disp(h_disp), .v_disp(v_disp), .lcd_de(lcd_de), .lcd_hs(lcd_hs),
        .lcd_vs(lcd_vs), .lcd_bl(lcd_bl), .lcd_rst(lcd_rst), .lcd_clk(lcd_clk),
        .lcd_rgb(lcd_rgb)
    );

    // Upstream source with one cycle of fetch latency; junk when nothing requested.
    logic          up_v;
    logic [CW-1:0] up_x, up_y;
    always @(posedge clk) begin
        up_v <= pixel_req;
        up_x <= pixel_xpos;
        up_y <= pixel_ypos;
    end
    assign pixel_data = up_v ? {up_y, up_x} : 24'hABCDEF;

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int hs, input int hb, input int hd, input int hf,
                           input int vs, input int vb, input int vd, input int vf,
                           input int hp, input int vp, input int dm);
        cfg_h_sync  = CW'(hs);
        cfg_h_back  = CW'(hb);
        cfg_h_disp  = CW'(hd);
        cfg_h_front = CW'(hf);
        cfg_v_sync  = CW'(vs);
        cfg_v_back  = CW'(vb);
        cfg_v_disp  = CW'(vd);
        cfg_v_front = CW'(vf);
        cfg_hs_pol  = (hp != 0);
        cfg_vs_pol  = (vp != 0);
        cfg_de_mode = (dm != 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_lcd_rst", 32'(lcd_rst), 0);
        chk("rst_lcd_bl", 32'(lcd_bl), 0);
        chk("rst_lcd_de", 32'(lcd_de), 0);
        chk("rst_pixel_req", 32'(pixel_req), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_line_start", 32'(line_start), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_lcd_rgb", 32'(lcd_rgb), 0);
        chk("rst_xpos", 32'(pixel_xpos), 0);
        chk("rst_ypos", 32'(pixel_ypos), 0);
        chk("rst_lcd_hs", 32'(lcd_hs), 1);
        chk("rst_lcd_vs", 32'(lcd_vs), 1);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_h_disp", 32'(h_disp), 480);
        chk("rst_v_disp", 32'(v_disp), 272);
    endtask

    task automatic wait_ready(input int bound);
        int i;
        i = 0;
        while (cfg_ready !== 1'b1 && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk("cfg_ready_wait", 32'(cfg_ready), 1);
    endtask

    task automatic wait_frame(input int bound);
        int i;
        i = 0;
        while (frame_start !== 1'b1 && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk("frame_sync", 32'(frame_start), 1);
    endtask

    function automatic int in_act(input int p, input int ht, input int h0, input int hd,
                                  input int v0, input int vd);
        int x, y;
        x = p % ht;
        y = p / ht;
        return (x >= h0 && x < h0 + hd && y >= v0 && y < v0 + vd) ? 1 : 0;
    endfunction

    // One full frame, cycle by cycle, starting at the first pixel_req of the frame.
    task automatic check_frame(input int hs, input int hb, input int hd, input int hf,
                               input int vs, input int vb, input int vd, input int vf,
                               input int hp, input int vp, input int dm);
        int ht, vt, ft, h0, v0, off, p, q, a, b, px, py, qx, qy, eh, ev, ergb;
        ht  = hs + hb + hd + hf;
        vt  = vs + vb + vd + vf;
        ft  = ht * vt;
        h0  = hs + hb;
        v0  = vs + vb;
        off = v0 * ht + h0;
        wait_frame(2 * ft + 20);
        for (int r = 0; r < ft; r++) begin
            p  = (off + r) % ft;
            q  = (off + r - int'(REQ_LEAD) + ft) % ft;
            a  = in_act(p, ht, h0, hd, v0, vd);
            b  = in_act(q, ht, h0, hd, v0, vd);
            px = p % ht;
            py = p / ht;
            qx = q % ht;
            qy = q / ht;
            eh = (dm != 0) ? 1 : ((qx < hs) ? hp : 1 - hp);
            ev = (dm != 0) ? 1 : ((qy < vs) ? vp : 1 - vp);
            ergb = (b != 0) ? (((qy - v0) << 12) | (qx - h0)) : 0;
            chk("pixel_req", 32'(pixel_req), a);
            chk("pixel_xpos", 32'(pixel_xpos), (a != 0) ? px - h0 : 0);
            chk("pixel_ypos", 32'(pixel_ypos), (a != 0) ? py - v0 : 0);
            chk("frame_start", 32'(frame_start), (a != 0 && px == h0 && py == v0) ? 1 : 0);
            chk("line_start", 32'(line_start), (a != 0 && px == h0) ? 1 : 0);
            chk("lcd_de", 32'(lcd_de), b);
            chk("lcd_hs", 32'(lcd_hs), eh);
            chk("lcd_vs", 32'(lcd_vs), ev);
            chk("lcd_rgb", 32'(lcd_rgb), ergb);
            @(negedge clk);
        end
    endtask

    initial begin
        int bl_cnt;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        bl_duty   = 8'hFF;
        set_cfg(2, 3, 8, 1, 1, 1, 4, 1, 0, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();

        // Power-up with the test config loaded during panel reset.
        rst       = 1'b0;
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("pwr_lcd_rst_1", 32'(lcd_rst), 0);
        chk("pwr_capture_ready", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("pwr_lcd_rst_2", 32'(lcd_rst), 0);
        chk("pwr_xfer_ready", 32'(cfg_ready), 1);
        chk("pwr_h_disp", 32'(h_disp), 8);
        chk("pwr_v_disp", 32'(v_disp), 4);
        @(negedge clk);
        chk("pwr_lcd_rst_3", 32'(lcd_rst), 0);
        @(negedge clk);
        chk("pwr_lcd_rst_up", 32'(lcd_rst), 1);
        chk("pwr_bl_off_0", 32'(lcd_bl), 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("pwr_bl_off", 32'(lcd_bl), 0);
        end
        @(negedge clk);
        chk("pwr_bl_on", 32'(lcd_bl), 1);
        @(negedge clk);
        chk("pwr_bl_on_2", 32'(lcd_bl), 1);

        // Geometry and data path in DE-only mode.
        check_frame(2, 3, 8, 1, 1, 1, 4, 1, 0, 0, 1);

        // Switch to real sync pulses, active low.
        set_cfg(2, 3, 8, 1, 1, 1, 4, 1, 0, 0, 0);
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("sync_capture_ready", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        wait_ready(120);
        check_frame(2, 3, 8, 1, 1, 1, 4, 1, 0, 0, 0);

        // Mid-frame reconfiguration; a second offer while busy is ignored.
        set_cfg(2, 3, 6, 1, 1, 1, 4, 1, 0, 0, 0);
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("recfg_ready_low", 32'(cfg_ready), 0);
        chk("recfg_h_disp_old", 32'(h_disp), 8);
        set_cfg(2, 3, 5, 1, 1, 1, 4, 1, 0, 0, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_ready(120);
        chk("recfg_h_disp_new", 32'(h_disp), 6);
        chk("recfg_v_disp", 32'(v_disp), 4);
        check_frame(2, 3, 6, 1, 1, 1, 4, 1, 0, 0, 0);

        // Rejected offers: zero v_disp, then horizontal total overflowing CW bits.
        set_cfg(2, 3, 6, 1, 1, 1, 0, 1, 0, 0, 0);
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("err_vdisp0_pulse", 32'(cfg_err), 1);
        chk("err_vdisp0_ready", 32'(cfg_ready), 1);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("err_vdisp0_clear", 32'(cfg_err), 0);
        set_cfg(2, 3, 4095, 1, 1, 1, 4, 1, 0, 0, 0);
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("err_ovf_pulse", 32'(cfg_err), 1);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("err_ovf_clear", 32'(cfg_err), 0);
        chk("err_ready", 32'(cfg_ready), 1);
        chk("err_h_disp_kept", 32'(h_disp), 6);
        chk("err_v_disp_kept", 32'(v_disp), 4);

        // PWM dimming at 64/256.
        bl_duty = 8'd64;
        repeat (3) @(negedge clk);
        bl_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (lcd_bl === 1'b1) bl_cnt++;
            @(negedge clk);
        end
        chk("pwm_high_count", 32'(bl_cnt), 64);

        // Reset in the middle of an active line.
        wait_frame(200);
        repeat (2) @(negedge clk);
        chk("midrst_pre_req", 32'(pixel_req), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_lcd_rst", 32'(lcd_rst), 0);
        chk("post_rst_req", 32'(pixel_req), 0);
        chk("post_rst_h_disp", 32'(h_disp), 480);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
